// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA timing generator with four runtime-selectable 3-3-2 patterns
module vga_pattern_gen #(
    parameter int   CLK_DIV  = 3,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic HS_ACT   = 1'b0,
    parameter logic VS_ACT   = 1'b0,
    parameter int   R_W      = 3,
    parameter int   G_W      = 3,
    parameter int   B_W      = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     mode,
    input  logic [9:0]     radius,
    output logic [R_W-1:0] red_F,
    output logic [G_W-1:0] green_F,
    output logic [B_W-1:0] blue_F,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic           frame_start,
    output logic [7:0]     frame_count
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int R_LG  = $clog2(V_ACTIVE);
    localparam int G_LG  = $clog2(H_ACTIVE);
    localparam int R_SH  = (R_LG > R_W) ? R_LG - R_W : 0;
    localparam int G_SH  = (G_LG > G_W) ? G_LG - G_W : 0;
    localparam logic [HW+2:0] HA_DIV = (HW+3)'(H_ACTIVE);

    logic [DW-1:0]    div_q;
    logic             pix_en;
    logic [HW-1:0]    h_q;
    logic [VW-1:0]    v_q;
    logic [7:0]       frame_count_q;
    logic [1:0]       mode_q;
    logic [9:0]       radius_q;

    logic             s1_vld_q, s1_vis_q, s1_hs_q, s1_vs_q;
    logic signed [11:0] s1_dx_q, s1_dy_q;
    logic [HW-1:0]    s1_h_q;
    logic [VW-1:0]    s1_v_q;

    logic [R_W-1:0]   red_q, red_d;
    logic [G_W-1:0]   green_q, green_d;
    logic [B_W-1:0]   blue_q, blue_d;
    logic             hsync_q, vsync_q, active_q, frame_start_q;

    logic             h_wrap, v_wrap;
    logic signed [11:0] dx_d, dy_d;
    logic [11:0]      adx, ady;
    logic [24:0]      dist2, rad2;
    logic             in_circle, chk_on;
    logic [2:0]       bar_idx;

    assign pix_en = (div_q == DW'(CLK_DIV - 1));
    assign h_wrap = (h_q == HW'(H_TOT - 1));
    assign v_wrap = (v_q == VW'(V_TOT - 1));
    assign dx_d   = 12'(h_q) - 12'(H_ACTIVE / 2);
    assign dy_d   = 12'(v_q) - 12'(V_ACTIVE / 2);

    // Pixel-enable divider: one pix_en every CLK_DIV system clocks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (pix_en) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Raster counters, frame counter and frame-boundary latch of mode/radius
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_count_q <= '0;
            mode_q        <= '0;
            radius_q      <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_q <= '0;
                if (v_wrap) begin
                    v_q           <= '0;
                    frame_count_q <= frame_count_q + 8'd1;
                    mode_q        <= mode;
                    radius_q      <= radius;
                end else begin
                    v_q <= v_q + 1'b1;
                end
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    // Stage 1: visibility, sync windows and centre-relative coordinates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_vis_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_dx_q  <= '0;
            s1_dy_q  <= '0;
            s1_h_q   <= '0;
            s1_v_q   <= '0;
        end else if (pix_en) begin
            s1_vld_q <= 1'b1;
            s1_vis_q <= (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
            s1_hs_q  <= (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
            s1_vs_q  <= (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
            s1_dx_q  <= dx_d;
            s1_dy_q  <= dy_d;
            s1_h_q   <= h_q;
            s1_v_q   <= v_q;
        end
    end

    assign adx       = s1_dx_q[11] ? (~s1_dx_q + 12'd1) : s1_dx_q;
    assign ady       = s1_dy_q[11] ? (~s1_dy_q + 12'd1) : s1_dy_q;
    assign dist2     = 25'(adx) * 25'(adx) + 25'(ady) * 25'(ady);
    assign rad2      = 25'(radius_q) * 25'(radius_q);
    assign in_circle = (dist2 <= rad2);
    assign chk_on    = 1'((12'(s1_h_q) + 12'(frame_count_q)) >> 5) ^ 1'(12'(s1_v_q) >> 5);
    assign bar_idx   = 3'({s1_h_q, 3'b000} / HA_DIV);

    // Pattern selection for the stage-1 pixel; blanked outside the visible area
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (s1_vis_q) begin
            case (mode_q)
                2'd0: begin
                    red_d   = R_W'(s1_v_q >> R_SH);
                    green_d = G_W'(s1_h_q >> G_SH);
                end
                2'd1: begin
                    if (in_circle) begin
                        red_d   = '1;
                        green_d = '1;
                        blue_d  = '1;
                    end
                end
                2'd2: begin
                    if (chk_on) begin
                        red_d   = '1;
                        green_d = '1;
                        blue_d  = '1;
                    end
                end
                default: begin
                    red_d   = {R_W{bar_idx[2]}};
                    green_d = {G_W{bar_idx[1]}};
                    blue_d  = {B_W{bar_idx[0]}};
                end
            endcase
        end
    end

    // Stage 2: registered outputs, syncs kept aligned with colour
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && s1_vld_q && (s1_h_q == '0) && (s1_v_q == '0);
            if (pix_en) begin
                red_q    <= red_d;
                green_q  <= green_d;
                blue_q   <= blue_d;
                hsync_q  <= s1_hs_q ? HS_ACT : ~HS_ACT;
                vsync_q  <= s1_vs_q ? VS_ACT : ~VS_ACT;
                active_q <= s1_vis_q;
            end
        end
    end

    assign red_F       = red_q;
    assign green_F     = green_q;
    assign blue_F      = blue_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - randomized self-checking bench for vga_pattern_gen on a reduced geometry
module tb_vga_pattern_gen;

    localparam int D   = 2;
    localparam int HA  = 12;
    localparam int HFP = 1;
    localparam int HSW = 2;
    localparam int HBP = 1;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FR  = HT * VT;
    localparam int RSH = $clog2(VA) - 3;
    localparam int GSH = $clog2(HA) - 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [9:0] radius = 10'd0;
    logic [2:0] red_F, green_F;
    logic [1:0] blue_F;
    logic       hsync, vsync, active, frame_start;
    logic [7:0] frame_count;

    int errs = 0;
    int checks = 0;
    int j = 0;
    int fmode [0:299];
    int frad  [0:299];

    vga_pattern_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_ACT(1'b0), .VS_ACT(1'b0), .R_W(3), .G_W(3), .B_W(2)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .radius(radius),
        .red_F(red_F), .green_F(green_F), .blue_F(blue_F),
        .hsync(hsync), .vsync(vsync), .active(active),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for raster position number n counted from the first pixel after reset
    task automatic model_pixel(input int n, output int r, output int g, output int b,
                               output int hs, output int vs, output int act);
        int h, v, f, fc, m, rad, dx, dy, idx;
        h   = n % HT;
        v   = (n / HT) % VT;
        f   = n / FR;
        fc  = f % 256;
        m   = fmode[f];
        rad = frad[f];
        act = (h < HA && v < VA) ? 1 : 0;
        hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? 0 : 1;
        vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? 0 : 1;
        r = 0; g = 0; b = 0;
        if (act == 1) begin
            case (m)
                0: begin
                    r = (v >> RSH) % 8;
                    g = (h >> GSH) % 8;
                end
                1: begin
                    dx = h - HA / 2;
                    dy = v - VA / 2;
                    if (dx * dx + dy * dy <= rad * rad) begin r = 7; g = 7; b = 3; end
                end
                2: begin
                    if ((((h + fc) / 32) % 2) != ((v / 32) % 2)) begin r = 7; g = 7; b = 3; end
                end
                default: begin
                    idx = (h * 8) / HA;
                    r = ((idx / 4) % 2) * 7;
                    g = ((idx / 2) % 2) * 7;
                    b = (idx % 2) * 3;
                end
            endcase
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_red"}, 32'(red_F), 0);
        check({tag, "_green"}, 32'(green_F), 0);
        check({tag, "_blue"}, 32'(blue_F), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_fstart"}, 32'(frame_start), 0);
        check({tag, "_fcount"}, 32'(frame_count), 0);
    endtask

    task automatic check_outputs();
        int k, r, g, b, hs, vs, act, fs;
        k = j / D;
        if (k >= 2) begin
            model_pixel(k - 2, r, g, b, hs, vs, act);
        end else begin
            r = 0; g = 0; b = 0; hs = 1; vs = 1; act = 0;
        end
        fs = (j % D == 0 && k >= 2 && (k - 2) % FR == 0) ? 1 : 0;
        check("red", 32'(red_F), r);
        check("green", 32'(green_F), g);
        check("blue", 32'(blue_F), b);
        check("hsync", 32'(hsync), hs);
        check("vsync", 32'(vsync), vs);
        check("active", 32'(active), act);
        check("frame_start", 32'(frame_start), fs);
        check("frame_count", 32'(frame_count), (k / FR) % 256);
    endtask

    // One system clock: note the mode/radius the DUT samples at frame wraps, then check after the edge
    task automatic step();
        int k;
        @(posedge clock);
        if (reset) begin
            j = 0;
        end else begin
            j++;
            if (j % D == 0) begin
                k = j / D;
                if (k % FR == 0 && k / FR < 300) begin
                    fmode[k / FR] = int'(mode);
                    frad[k / FR]  = int'(radius);
                end
            end
        end
        #1;
        if (reset) check_reset_state("rst");
        else check_outputs();
    endtask

    task automatic maybe_change_mode();
        if ($urandom_range(0, 149) == 0) begin
            mode   = 2'($urandom_range(0, 3));
            radius = 10'($urandom_range(0, 7));
        end
    endtask

    initial begin
        fmode[0] = 0;
        frad[0]  = 0;
        repeat (3) step();
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 3 * FR * D + 37; i++) begin
            step();
            maybe_change_mode();
        end

        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        repeat (3) step();
        fmode[0] = 0;
        frad[0]  = 0;
        mode     = 2'd3;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < (257 * FR + 10) * D; i++) begin
            step();
            maybe_change_mode();
        end
        check("frame_count_after_257", 32'(frame_count), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor of the current VGA shader block.
- Generates VGA timing from a fast system clock via an internal pixel-enable divider, with the timing geometry configurable by parameter.
- Renders one of four runtime-selectable pixel patterns into a 3-3-2 RGB output.
- Provides a registered, latency-matched pipeline, a frame counter for animation, and glitch-free mode switching at frame boundaries.

Parameters:
- CLK_DIV, 3: system clocks per pixel; legal range ≥1.
- H_ACTIVE, 800; H_FP, 40; H_SYNC, 128; H_BP, 88: horizontal timing in pixels; line total is 1056.
- V_ACTIVE, 600; V_FP, 1; V_SYNC, 4; V_BP, 23: vertical timing in lines; frame total is 628.
- HS_ACT, 0: asserted level of hsync.
- VS_ACT, 0: asserted level of vsync.
- R_W, 3; G_W, 3; B_W, 2: colour channel widths.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- mode, in, 2: pattern select (0 gradient, 1 circle, 2 checker, 3 colour bars).
- radius, in, 10: circle radius in pixels (mode 1).
- red_F, out, R_W: red channel.
- green_F, out, G_W: green channel.
- blue_F, out, B_W: blue channel.
- hsync, out, 1: horizontal sync.
- vsync, out, 1: vertical sync.
- active, out, 1: high while the displayed pixel is in the visible area.
- frame_start, out, 1: one-clock pulse.
- frame_count, out, 8: completed-frame counter.

Behaviour:
- Reset:
  - Clock-divider counter, h and v counters, frame_count and all pipeline registers clear.
  - Colour outputs, active and frame_start are 0.
  - hsync = ~HS_ACT and vsync = ~VS_ACT.
  - Reset is honoured at any point, including mid-line. After release, the sequence restarts at h=0, v=0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is high for exactly one clock, when div==CLK_DIV-1.
  - With CLK_DIV=1, pix_en is constantly high.
  - All state below advances only on pix_en.
- Counters:
  - h counts 0..H_TOT-1, where H_TOT = sum of the four horizontal parameters.
  - On the h wrap, v counts 0..V_TOT-1.
  - When both wrap together, frame_count increments modulo 256.
- Stage 1, registered on pix_en:
  - vis = (h<H_ACTIVE && v<V_ACTIVE).
  - hs asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
  - Signed 12-bit dx = h − H_ACTIVE/2 and dy = v − V_ACTIVE/2.
  - Copy h, v.
- Stage 2, registered on pix_en: the colour is computed from the stage-1 values.
  - Mode 0, gradient:
    - red_F = v >> (clog2(V_ACTIVE) − R_W), truncated.
    - green_F = h >> (clog2(H_ACTIVE) − G_W), truncated.
    - blue_F = 0.
  - Mode 1, circle:
    - The comparison dx²+dy² ≤ radius² uses full 25-bit unsigned products with no truncation.
    - True gives all channels all-ones; false gives 0.
  - Mode 2, checker: ((h + frame_count)[5] ^ v[5]) gives all-ones, otherwise 0. The pattern scrolls 1 px per frame.
  - Mode 3, bars:
    - idx = (h*8)/H_ACTIVE, in the range 0..7.
    - red_F = idx[2] replicated, green_F = idx[1] replicated, blue_F = idx[0] replicated.
  - When !vis, all colours are 0 regardless of mode.
  - hsync, vsync and active are taken from the stage-1 hs, vs and vis, so they stay aligned with the colour.
- Latency:
  - Outputs for counter position (h,v) appear 2 pix_en events after the counters hold (h,v).
  - Outputs are held constant between pix_en events.
- Mode latch:
  - mode and radius are sampled into internal registers only on the pix_en where the counters wrap to (0,0).
  - Changes mid-frame therefore take effect from the first pixel of the next frame. There is no tearing.
  - Out of reset, the latched mode is 0 and the latched radius is 0.
- frame_start:
  - High for exactly one clock: the clock on which the outputs for pixel (0,0) are first presented.
- Boundaries:
  - h=H_ACTIVE−1 is the last visible pixel; h=H_ACTIVE is black with active=0.
  - The bars index never exceeds 7.
  - With radius=0, only the centre pixel is lit.
  - frame_count 255 wraps to 0.

Test Plan:
- Reset and sync timing: assert reset mid-line, then release.
  - All outputs are 0 and syncs inactive during reset.
  - After release, hsync is low for exactly 128×3 = 384 clocks per 3168-clock line, starting 840 pixels after line start.
  - vsync is low for 4 lines per 628-line frame.
- Gradient, mode 0: read outputs at pixel (256,384).
  - Required: green_F=2, red_F=3, blue_F=0, active=1, 2 pix_en after the counters reach that position.
- Circle, mode 1 with radius=100:
  - Pixels (400,300) and (500,300) are white (7,7,3).
  - Pixel (501,300) is black.
  - Pixel (900,300) is black with active=0.
- Bars, mode 3:
  - h=0..99 gives black.
  - h=100 gives blue=3 with red=green=0.
  - h=799 gives white.
- Mode latch: switch mode 0 to 2 at v=300.
  - The rest of the frame stays gradient.
  - The checker appears from (0,0) of the next frame.
  - frame_start pulses exactly once per frame.
- Animation and wrap:
  - Run 257 frames; frame_count reads 1.
  - In mode 2, the checker pattern at pixel (0,0) alternates every 32 frames.
